phoenix_memory_arbiter: RTL and testbench

Shares one single-port memory between the phoeniX core's instruction and data memory interfaces.
- Each requester gets a req/ready handshake.
- The arbiter serialises accesses, drives one registered memory command, captures read data after a fixed memory latency and returns it to the winning requester.
- Data accesses have priority. A starvation counter guarantees forward progress for instruction fetch.

---
 rtl/phoenix_memory_arbiter_if.sv | 40 ++++
 rtl/phoenix_memory_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_phoenix_memory_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phoenix_memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// phoenix_memory_arbiter_if
//
// Purpose : one requester channel of the phoeniX memory arbiter. The core's
//           instruction port and data port each use one instance.
//
// Signals : req         request, held until ready
//           state       0 = READ, 1 = WRITE
//           address     byte address
//           frame_mask  byte enables (DATA_WIDTH/8 bits)
//           wdata       write data
//           rdata       read data, valid while ready = 1
//           ready       one-cycle completion pulse
//
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface phoenix_memory_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    req;
  logic                    state;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] frame_mask;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    ready;

  modport master (
    output req, state, address, frame_mask, wdata,
    input  rdata, ready
  );

  modport slave (
    input  req, state, address, frame_mask, wdata,
    output rdata, ready
  );

endinterface : phoenix_memory_arbiter_if

// File: rtl/phoenix_memory_arbiter.sv
// -----------------------------------------------------------------------------
// phoenix_memory_arbiter
//
// Purpose : shares one single-port memory between the phoeniX instruction and
//           data interfaces. One access is in flight at a time:
//             IDLE  -> arbitrate, register the winner's command into mem_*
//             ISSUE -> mem_enable high for this single cycle
//             WAIT  -> count MEM_LATENCY cycles, capture mem_rdata on a read
//             DONE  -> one-cycle ready pulse to the winner
//           Data wins ties, except after STARVE_LIMIT consecutive data grants
//           made while instruction fetch was waiting.
//
// Ports   : clk            clock, rising edge
//           reset          asynchronous, active-low
//           instr_if       instruction requester channel (slave side)
//           data_if        data requester channel (slave side)
//           mem_enable     memory command strobe, one cycle per access
//           mem_state      0 = READ, 1 = WRITE
//           mem_address    registered address
//           mem_frame_mask registered byte enables
//           mem_wdata      registered write data
//           mem_rdata      memory read data, valid MEM_LATENCY cycles after
//                          the mem_enable cycle
//           grant_data     1 while the current/last grant belongs to data
// -----------------------------------------------------------------------------
module phoenix_memory_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,   // legal 1..15
  parameter int STARVE_LIMIT = 4    // legal 1..15
) (
  input  logic                    clk,
  input  logic                    reset,

  phoenix_memory_arbiter_if.slave instr_if,
  phoenix_memory_arbiter_if.slave data_if,

  output logic                    mem_enable,
  output logic                    mem_state,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH/8-1:0] mem_frame_mask,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,

  output logic                    grant_data
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  localparam logic ST_READ = 1'b0;

  // Both counters fit the 1..15 parameter range.
  localparam logic [3:0] LATENCY_C = 4'(MEM_LATENCY);
  localparam logic [3:0] STARVE_C  = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                  state_q,          state_d;
  logic                    mem_state_q,      mem_state_d;
  logic [ADDR_WIDTH-1:0]   mem_address_q,    mem_address_d;
  logic [MASK_WIDTH-1:0]   mem_frame_mask_q, mem_frame_mask_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q,      mem_wdata_d;
  logic                    grant_data_q,     grant_data_d;
  logic [3:0]              lat_cnt_q,        lat_cnt_d;
  logic [3:0]              starve_q,         starve_d;
  logic [DATA_WIDTH-1:0]   instr_rdata_q,    instr_rdata_d;
  logic [DATA_WIDTH-1:0]   data_rdata_q,     data_rdata_d;

  // Arbitration result for the current IDLE cycle.
  logic                    pick_data;

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case statement, so no
    // path through the block leaves one unassigned and no latch is inferred.
    state_d          = state_q;
    mem_state_d      = mem_state_q;
    mem_address_d    = mem_address_q;
    mem_frame_mask_d = mem_frame_mask_q;
    mem_wdata_d      = mem_wdata_q;
    grant_data_d     = grant_data_q;
    lat_cnt_d        = lat_cnt_q;
    starve_d         = starve_q;
    instr_rdata_d    = instr_rdata_q;
    data_rdata_d     = data_rdata_q;
    pick_data        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // No instruction waiting means nothing is being starved.
        if (!instr_if.req) begin
          starve_d = '0;
        end

        if (instr_if.req || data_if.req) begin
          // Data wins unless instruction fetch has waited out its budget.
          pick_data    = data_if.req && !(instr_if.req && (starve_q == STARVE_C));
          grant_data_d = pick_data;
          state_d      = S_ISSUE;

          if (pick_data) begin
            mem_state_d      = data_if.state;
            mem_address_d    = data_if.address;
            mem_frame_mask_d = data_if.frame_mask;
            mem_wdata_d      = data_if.wdata;
            if (instr_if.req && (starve_q != STARVE_C)) begin
              starve_d = starve_q + 4'd1;
            end
          end else begin
            mem_state_d      = instr_if.state;
            mem_address_d    = instr_if.address;
            mem_frame_mask_d = instr_if.frame_mask;
            mem_wdata_d      = instr_if.wdata;
            starve_d         = '0;
          end
        end
      end

      S_ISSUE: begin
        lat_cnt_d = LATENCY_C;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        // A count of 1 marks the cycle in which mem_rdata is valid.
        if (lat_cnt_q == 4'd1) begin
          state_d = S_DONE;
          if (mem_state_q == ST_READ) begin
            if (grant_data_q) begin
              data_rdata_d = mem_rdata;
            end else begin
              instr_rdata_d = mem_rdata;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      mem_state_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_frame_mask_q <= '0;
      mem_wdata_q      <= '0;
      grant_data_q     <= 1'b0;
      lat_cnt_q        <= '0;
      starve_q         <= '0;
      instr_rdata_q    <= '0;
      data_rdata_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values present before the edge, independent of statement order.
      state_q          <= state_d;
      mem_state_q      <= mem_state_d;
      mem_address_q    <= mem_address_d;
      mem_frame_mask_q <= mem_frame_mask_d;
      mem_wdata_q      <= mem_wdata_d;
      grant_data_q     <= grant_data_d;
      lat_cnt_q        <= lat_cnt_d;
      starve_q         <= starve_d;
      instr_rdata_q    <= instr_rdata_d;
      data_rdata_q     <= data_rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Strobe and ready decode straight from the state register, so an
  // asynchronous reset removes them in the same instant.
  assign mem_enable     = (state_q == S_ISSUE);
  assign mem_state      = mem_state_q;
  assign mem_address    = mem_address_q;
  assign mem_frame_mask = mem_frame_mask_q;
  assign mem_wdata      = mem_wdata_q;
  assign grant_data     = grant_data_q;

  assign instr_if.rdata = instr_rdata_q;
  assign data_if.rdata  = data_rdata_q;
  assign instr_if.ready = (state_q == S_DONE) && !grant_data_q;
  assign data_if.ready  = (state_q == S_DONE) &&  grant_data_q;

endmodule : phoenix_memory_arbiter

// File: tb/tb_phoenix_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_phoenix_memory_arbiter
//
// Two arbiters: u_dut1 (MEM_LATENCY=1) and u_dut3 (MEM_LATENCY=3). The bench
// drives one of them at a time (sel). A transaction-level model predicts the
// winner, the cycle of every strobe/ready and the returned read data; a
// behavioural memory answers the arbiter's commands.
// -----------------------------------------------------------------------------
module tb_phoenix_memory_arbiter;

  localparam int   STARVE_LIMIT = 4;
  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  typedef struct {
    logic        vld;
    logic        st;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  bit   sel = 1'b0;            // 0 -> u_dut1, 1 -> u_dut3

  req_t ireq, dreq;
  logic [31:0] mem_rdata_tb;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state
  int          m_starve;
  logic [31:0] exp_irdata, exp_drdata;
  logic [31:0] ref_mem [logic [31:0]];

  // Behavioural memory state
  logic [31:0] dev_mem [logic [31:0]];
  bit          pend_vld = 1'b0;
  int          pend_due;
  logic [31:0] pend_data;

  bit starve_pat [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  phoenix_memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) i1_if ();
  phoenix_memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) d1_if ();
  phoenix_memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) i3_if ();
  phoenix_memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) d3_if ();

  logic        m1_en, m1_st, m1_gd, m3_en, m3_st, m3_gd;
  logic [31:0] m1_addr, m1_wdata, m3_addr, m3_wdata;
  logic [3:0]  m1_mask, m3_mask;

  phoenix_memory_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(STARVE_LIMIT)) u_dut1 (
    .clk(clk), .reset(reset), .instr_if(i1_if), .data_if(d1_if),
    .mem_enable(m1_en), .mem_state(m1_st), .mem_address(m1_addr),
    .mem_frame_mask(m1_mask), .mem_wdata(m1_wdata), .mem_rdata(mem_rdata_tb),
    .grant_data(m1_gd)
  );

  phoenix_memory_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(STARVE_LIMIT)) u_dut3 (
    .clk(clk), .reset(reset), .instr_if(i3_if), .data_if(d3_if),
    .mem_enable(m3_en), .mem_state(m3_st), .mem_address(m3_addr),
    .mem_frame_mask(m3_mask), .mem_wdata(m3_wdata), .mem_rdata(mem_rdata_tb),
    .grant_data(m3_gd)
  );

  // Requester fields go to both channels; only the selected one sees req.
  assign i1_if.req = !sel && ireq.vld;
  assign d1_if.req = !sel && dreq.vld;
  assign i3_if.req =  sel && ireq.vld;
  assign d3_if.req =  sel && dreq.vld;
  assign i1_if.state = ireq.st;    assign i3_if.state = ireq.st;
  assign i1_if.address = ireq.addr; assign i3_if.address = ireq.addr;
  assign i1_if.frame_mask = ireq.mask; assign i3_if.frame_mask = ireq.mask;
  assign i1_if.wdata = ireq.wdata; assign i3_if.wdata = ireq.wdata;
  assign d1_if.state = dreq.st;    assign d3_if.state = dreq.st;
  assign d1_if.address = dreq.addr; assign d3_if.address = dreq.addr;
  assign d1_if.frame_mask = dreq.mask; assign d3_if.frame_mask = dreq.mask;
  assign d1_if.wdata = dreq.wdata; assign d3_if.wdata = dreq.wdata;

  // Observed outputs of the selected arbiter.
  logic        o_en, o_st, o_gd, o_iready, o_dready;
  logic [31:0] o_addr, o_wdata, o_irdata, o_drdata;
  logic [3:0]  o_mask;
  assign o_en     = sel ? m3_en    : m1_en;
  assign o_st     = sel ? m3_st    : m1_st;
  assign o_gd     = sel ? m3_gd    : m1_gd;
  assign o_addr   = sel ? m3_addr  : m1_addr;
  assign o_wdata  = sel ? m3_wdata : m1_wdata;
  assign o_mask   = sel ? m3_mask  : m1_mask;
  assign o_iready = sel ? i3_if.ready : i1_if.ready;
  assign o_dready = sel ? d3_if.ready : d1_if.ready;
  assign o_irdata = sel ? i3_if.rdata : i1_if.rdata;
  assign o_drdata = sel ? d3_if.rdata : d1_if.rdata;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] dev_read(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.vld   = 1'b1;
    r.st    = 1'($urandom_range(0, 1));
    r.addr  = 32'($urandom_range(0, 7)) << 2;
    r.mask  = 4'($urandom);
    r.wdata = $urandom;
    return r;
  endfunction

  // Memory: read data appears only in the cycle MEM_LATENCY after the
  // command; every other cycle carries noise.
  always @(negedge clk) begin
    if (!reset) pend_vld = 1'b0;
    if (pend_vld && cyc == pend_due) begin
      mem_rdata_tb = pend_data;
      pend_vld     = 1'b0;
    end else begin
      mem_rdata_tb = $urandom;
    end
    if (reset && o_en) begin
      pend_due = cyc + (sel ? 3 : 1);
      if (o_st == READ) begin
        pend_vld  = 1'b1;
        pend_data = dev_read(o_addr);
      end else begin
        dev_mem[o_addr] = merge(dev_read(o_addr), o_wdata, o_mask);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    check({tag, ".mem_enable"},  32'(o_en),     32'd0);
    check({tag, ".instr_ready"}, 32'(o_iready), 32'd0);
    check({tag, ".data_ready"},  32'(o_dready), 32'd0);
  endtask

  // Entry: at a negedge of an IDLE cycle with requests already applied, or
  // (from_done) at the negedge of the previous DONE cycle.
  task automatic run_txn(input string tag, input bit from_done, output logic gd_obs);
    logic pick_d;
    req_t w;
    int   lat;
    lat = sel ? 3 : 1;
    if (from_done) @(negedge clk);

    // Arbitration by rule: data first, unless fetch has been passed over
    // STARVE_LIMIT times in a row.
    pick_d = dreq.vld && !(ireq.vld && m_starve == STARVE_LIMIT);
    if (pick_d) begin
      w = dreq;
      m_starve = ireq.vld ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT) : 0;
    end else begin
      w = ireq;
      m_starve = 0;
    end
    if (w.st == READ) begin
      if (pick_d) exp_drdata = model_read(w.addr);
      else        exp_irdata = model_read(w.addr);
    end else begin
      ref_mem[w.addr] = merge(model_read(w.addr), w.wdata, w.mask);
    end

    @(posedge clk);
    @(negedge clk);  // command cycle
    check({tag, ".issue.mem_enable"},     32'(o_en),     32'd1);
    check({tag, ".issue.mem_state"},      32'(o_st),     32'(w.st));
    check({tag, ".issue.mem_address"},    o_addr,        w.addr);
    check({tag, ".issue.mem_frame_mask"}, 32'(o_mask),   32'(w.mask));
    check({tag, ".issue.mem_wdata"},      o_wdata,       w.wdata);
    check({tag, ".issue.grant_data"},     32'(o_gd),     32'(pick_d));
    check({tag, ".issue.instr_ready"},    32'(o_iready), 32'd0);
    check({tag, ".issue.data_ready"},     32'(o_dready), 32'd0);
    gd_obs = o_gd;

    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      idle_check({tag, ".wait"});
    end

    @(negedge clk);  // completion cycle
    check({tag, ".done.mem_enable"},  32'(o_en),     32'd0);
    check({tag, ".done.instr_ready"}, 32'(o_iready), 32'(!pick_d));
    check({tag, ".done.data_ready"},  32'(o_dready), 32'(pick_d));
    check({tag, ".done.instr_rdata"}, o_irdata,      exp_irdata);
    check({tag, ".done.data_rdata"},  o_drdata,      exp_drdata);
    check({tag, ".done.grant_data"},  32'(o_gd),     32'(pick_d));
  endtask

  task automatic random_phase(input string tag, input int n);
    logic gd;
    bit   from_done;
    from_done = 1'b0;  // entered at an IDLE negedge with nothing requested
    for (int t = 0; t < n; t++) begin
      if (!ireq.vld && !dreq.vld) begin
        if (from_done) @(negedge clk);
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          idle_check({tag, ".gap"});
        end
        case ($urandom_range(0, 2))
          0:       ireq = rand_req();
          1:       dreq = rand_req();
          default: begin ireq = rand_req(); dreq = rand_req(); end
        endcase
        from_done = 1'b0;
      end else begin
        if (!ireq.vld && $urandom_range(0, 1) == 1) ireq = rand_req();
        if (!dreq.vld && $urandom_range(0, 1) == 1) dreq = rand_req();
      end
      run_txn(tag, from_done, gd);
      from_done = 1'b1;
      // The winner either follows up at once or drops its request.
      if (gd) begin
        if ($urandom_range(0, 3) != 0) dreq = rand_req(); else dreq.vld = 1'b0;
      end else begin
        if ($urandom_range(0, 3) != 0) ireq = rand_req(); else ireq.vld = 1'b0;
      end
    end
    ireq.vld = 1'b0;
    dreq.vld = 1'b0;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic gd;
    reset      = 1'b0;
    ireq       = '{1'b0, READ, 32'h0, 4'h0, 32'h0};
    dreq       = '{1'b0, READ, 32'h0, 4'h0, 32'h0};
    m_starve   = 0;
    exp_irdata = '0;
    exp_drdata = '0;
    ref_mem[32'h10] = 32'h0051_3093;
    dev_mem[32'h10] = 32'h0051_3093;

    // Reset values
    #1;
    check("rst.mem_enable",     32'(m1_en),       32'd0);
    check("rst.mem_state",      32'(m1_st),       32'd0);
    check("rst.mem_address",    m1_addr,          32'd0);
    check("rst.mem_frame_mask", 32'(m1_mask),     32'd0);
    check("rst.mem_wdata",      m1_wdata,         32'd0);
    check("rst.grant_data",     32'(m1_gd),       32'd0);
    check("rst.instr_ready",    32'(i1_if.ready), 32'd0);
    check("rst.data_ready",     32'(d1_if.ready), 32'd0);
    check("rst.instr_rdata",    i1_if.rdata,      32'd0);
    check("rst.data_rdata",     d1_if.rdata,      32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single instruction read
    ireq = '{1'b1, READ, 32'h0000_0010, 4'hF, 32'h0};
    run_txn("read1", 1'b0, gd);
    check("read1.instr_rdata_value", o_irdata, 32'h0051_3093);
    ireq.vld = 1'b0;
    @(negedge clk);

    // Single data write; data_rdata must keep its value
    dreq = '{1'b1, WRITE, 32'h1000_0000, 4'b0001, 32'h0000_0041};
    run_txn("write1", 1'b0, gd);
    dreq.vld = 1'b0;
    @(negedge clk);

    // Simultaneous requests: data first, then instruction
    ireq = '{1'b1, READ, 32'h14, 4'hF, 32'h0};
    dreq = '{1'b1, READ, 32'h18, 4'hF, 32'h0};
    run_txn("both.first", 1'b0, gd);
    check("both.first_is_data", 32'(gd), 32'd1);
    dreq.vld = 1'b0;
    run_txn("both.second", 1'b1, gd);
    check("both.second_is_instr", 32'(gd), 32'd0);
    ireq.vld = 1'b0;
    @(negedge clk);

    // Starvation: fetch waits, data re-requests back to back
    ireq = '{1'b1, READ, 32'h40, 4'hF, 32'h0};
    dreq = '{1'b1, READ, 32'h44, 4'hF, 32'h0};
    for (int i = 0; i < 6; i++) begin
      run_txn("starve", i != 0, gd);
      check($sformatf("starve.grant%0d", i), 32'(gd), 32'(starve_pat[i]));
      if (gd) dreq.addr = dreq.addr + 32'd8;
      else    ireq.addr = ireq.addr + 32'd8;
    end
    ireq.vld = 1'b0;
    dreq.vld = 1'b0;
    @(negedge clk);

    random_phase("rnd1", 40);

    // Switch to the MEM_LATENCY=3 arbiter
    sel        = 1'b1;
    m_starve   = 0;
    exp_irdata = '0;
    exp_drdata = '0;
    @(negedge clk);

    ireq = '{1'b1, READ, 32'h20, 4'hF, 32'h0};
    run_txn("lat3.read", 1'b0, gd);
    ireq.vld = 1'b0;
    @(negedge clk);

    // Reset in the middle of WAIT
    dreq = '{1'b1, READ, 32'h28, 4'hF, 32'h0};
    @(posedge clk);
    @(negedge clk);  // command cycle
    check("rstwait.issue.mem_enable", 32'(o_en), 32'd1);
    @(negedge clk);  // first WAIT cycle
    reset    = 1'b0;
    dreq.vld = 1'b0;
    #1;
    check("rstwait.mem_enable",   32'(o_en),        32'd0);
    check("rstwait.instr_ready",  32'(o_iready),    32'd0);
    check("rstwait.data_ready",   32'(o_dready),    32'd0);
    check("rstwait.mem_address",  o_addr,           32'd0);
    check("rstwait.grant_data",   32'(o_gd),        32'd0);
    check("rstwait.dut1_iready",  32'(i1_if.ready), 32'd0);
    check("rstwait.dut1_dready",  32'(d1_if.ready), 32'd0);
    m_starve   = 0;
    exp_irdata = '0;
    exp_drdata = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle_check("rstwait.after");
    end

    dreq = '{1'b1, READ, 32'h2C, 4'hF, 32'h0};
    run_txn("rstwait.fresh", 1'b0, gd);
    dreq.vld = 1'b0;
    @(negedge clk);

    random_phase("rnd3", 15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1);
  end

endmodule : tb_phoenix_memory_arbiter
